// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the match-3 game-flow logic.
//   - OP_* : operation codes sent to the operate datapath on op_code
//   - state_t : swap_sequencer FSM states (also visible on dbg_state)
//   - BOARD_N_DEFAULT : default board side length
//   - opposite_dir() : maps a direction op code to its reverse, used to undo
//     a swap that produced no match
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int BOARD_N_DEFAULT = 8;

    localparam logic [3:0] OP_NONE   = 4'd0;
    localparam logic [3:0] OP_SELECT = 4'd1;
    localparam logic [3:0] OP_UP     = 4'd2;
    localparam logic [3:0] OP_DOWN   = 4'd3;
    localparam logic [3:0] OP_LEFT   = 4'd4;
    localparam logic [3:0] OP_RIGHT  = 4'd5;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_SWAP_WAIT   = 3'd1,
        ST_CHECK       = 3'd2,
        ST_FALL        = 3'd3,
        ST_REVERT_WAIT = 3'd4,
        ST_DONE        = 3'd5
    } state_t;

    function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
        case (dir)
            OP_UP:    opposite_dir = OP_DOWN;
            OP_DOWN:  opposite_dir = OP_UP;
            OP_LEFT:  opposite_dir = OP_RIGHT;
            OP_RIGHT: opposite_dir = OP_LEFT;
            default:  opposite_dir = OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cursor_ctrl.sv
// ---------------------------------------------------------------------------
// cursor_ctrl
// Combinational cursor stepper: given the current cell and a direction op
// code, returns the neighbouring cell, clamped to the board.
//   i_x, i_y   current column / row
//   i_dir      OP_UP / OP_DOWN / OP_LEFT / OP_RIGHT (anything else: no move)
//   o_x, o_y   stepped (or unchanged, if at the edge) position
//   o_at_edge  1 when the step would leave the board
// Up decreases the row, left decreases the column.
// ---------------------------------------------------------------------------
module cursor_ctrl
    import game_pkg::*;
#(
    parameter int BOARD_N = BOARD_N_DEFAULT
) (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    input  logic [3:0] i_dir,
    output logic [3:0] o_x,
    output logic [3:0] o_y,
    output logic       o_at_edge
);

    localparam logic [3:0] MAX_POS = 4'(BOARD_N - 1);

    always_comb begin
        o_x       = i_x;
        o_y       = i_y;
        o_at_edge = 1'b0;
        case (i_dir)
            OP_UP: begin
                if (i_y == 4'd0) o_at_edge = 1'b1;
                else             o_y = i_y - 4'd1;
            end
            OP_DOWN: begin
                if (i_y == MAX_POS) o_at_edge = 1'b1;
                else                o_y = i_y + 4'd1;
            end
            OP_LEFT: begin
                if (i_x == 4'd0) o_at_edge = 1'b1;
                else             o_x = i_x - 4'd1;
            end
            OP_RIGHT: begin
                if (i_x == MAX_POS) o_at_edge = 1'b1;
                else                o_x = i_x + 4'd1;
            end
            default: o_at_edge = 1'b0;
        endcase
    end

endmodule

// File: rtl/swap_sequencer.sv
// ---------------------------------------------------------------------------
// swap_sequencer
// Game-flow controller for the match-3 board: cursor movement, selection,
// swap commands to operate, then the match -> fall cascade loop. A swap that
// yields no match on its first scan is undone with the opposite move.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   btn_up/down/left/right/center   one-cycle debounced press pulses
//   cursor_x, cursor_y, selected    cursor state to operate
//   op_valid, op_code, op_moved     operate command / result (result arrives
//                                   the cycle after op_valid)
//   match_req, match_done, match_found   match engine
//   fall_req, fall_done             fall engine
//   busy                            state != IDLE
//   chain_done, combo               end of a successful cascade + its length
//   err_timeout                     sticky watchdog abort flag
//   dbg_state                       current FSM state (state_t encoding)
// Handshake: every *_req / op_valid / chain_done output is a registered strobe,
// high for exactly one cycle; there is no ready/back-pressure. Engine
// *_done inputs are one-cycle pulses and are only honoured in the state that
// waits for them; pulses arriving in any other state are ignored.
// ---------------------------------------------------------------------------
module swap_sequencer
    import game_pkg::*;
#(
    parameter int BOARD_N = BOARD_N_DEFAULT,
    parameter int COMBO_W = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_center,
    output logic [3:0]         cursor_x,
    output logic [3:0]         cursor_y,
    output logic               selected,
    output logic               op_valid,
    output logic [3:0]         op_code,
    input  logic               op_moved,
    output logic               match_req,
    input  logic               match_done,
    input  logic               match_found,
    output logic               fall_req,
    input  logic               fall_done,
    output logic               busy,
    output logic               chain_done,
    output logic [COMBO_W-1:0] combo,
    output logic               err_timeout,
    output logic [2:0]         dbg_state
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_t             r_state;
    logic [3:0]         r_x, r_y, r_dir, r_op_code;
    logic               r_sel, r_op_valid, r_match_req, r_fall_req, r_chain_done, r_err;
    logic [COMBO_W-1:0] r_combo;
    logic [WD_W-1:0]    r_wd;

    logic [3:0] w_btn_dir, w_dir, w_step_x, w_step_y;
    logic       w_at_edge;

    // Center is handled first by the FSM; among directions up wins, then down,
    // left, right.
    always_comb begin
        w_btn_dir = OP_NONE;
        if (btn_up)         w_btn_dir = OP_UP;
        else if (btn_down)  w_btn_dir = OP_DOWN;
        else if (btn_left)  w_btn_dir = OP_LEFT;
        else if (btn_right) w_btn_dir = OP_RIGHT;
    end

    // One stepper serves all states: live button in IDLE, the undo direction
    // while reverting, the remembered swap direction otherwise.
    always_comb begin
        case (r_state)
            ST_IDLE:        w_dir = w_btn_dir;
            ST_REVERT_WAIT: w_dir = opposite_dir(r_dir);
            default:        w_dir = r_dir;
        endcase
    end

    cursor_ctrl #(.BOARD_N(BOARD_N)) u_cursor (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_dir     (w_dir),
        .o_x       (w_step_x),
        .o_y       (w_step_y),
        .o_at_edge (w_at_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_x          <= 4'd0;
            r_y          <= 4'd0;
            r_dir        <= OP_NONE;
            r_sel        <= 1'b0;
            r_op_valid   <= 1'b0;
            r_op_code    <= OP_NONE;
            r_match_req  <= 1'b0;
            r_fall_req   <= 1'b0;
            r_chain_done <= 1'b0;
            r_combo      <= '0;
            r_err        <= 1'b0;
            r_wd         <= '0;
        end else begin
            r_op_valid   <= 1'b0;
            r_op_code    <= OP_NONE;
            r_match_req  <= 1'b0;
            r_fall_req   <= 1'b0;
            r_chain_done <= 1'b0;
            // Watchdog only runs in the engine-wait states; CHECK<->FALL
            // hand-offs clear it explicitly below.
            if (r_state == ST_CHECK || r_state == ST_FALL) r_wd <= r_wd + 1'b1;
            else                                           r_wd <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (btn_center) begin
                        r_sel <= ~r_sel;
                    end else if (w_btn_dir != OP_NONE) begin
                        if (!r_sel) begin
                            r_x <= w_step_x;
                            r_y <= w_step_y;
                        end else if (!w_at_edge) begin
                            // Cursor stays on the origin cell while operate
                            // performs the swap.
                            r_op_valid <= 1'b1;
                            r_op_code  <= w_btn_dir;
                            r_dir      <= w_btn_dir;
                            r_state    <= ST_SWAP_WAIT;
                        end
                    end
                end
                ST_SWAP_WAIT: begin
                    r_sel <= 1'b0;
                    if (op_moved) begin
                        r_x         <= w_step_x;
                        r_y         <= w_step_y;
                        r_combo     <= '0;
                        r_match_req <= 1'b1;
                        r_state     <= ST_CHECK;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (match_done) begin
                        if (match_found) begin
                            r_fall_req <= 1'b1;
                            r_wd       <= '0;
                            r_state    <= ST_FALL;
                        end else if (r_combo == '0) begin
                            // Undo from the target cell; the cursor walks back
                            // to the origin in REVERT_WAIT.
                            r_op_valid <= 1'b1;
                            r_op_code  <= opposite_dir(r_dir);
                            r_state    <= ST_REVERT_WAIT;
                        end else begin
                            r_chain_done <= 1'b1;
                            r_state      <= ST_DONE;
                        end
                    end else if (r_wd == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_sel   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_FALL: begin
                    if (fall_done) begin
                        if (r_combo != {COMBO_W{1'b1}}) r_combo <= r_combo + 1'b1;
                        r_match_req <= 1'b1;
                        r_wd        <= '0;
                        r_state     <= ST_CHECK;
                    end else if (r_wd == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_sel   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_REVERT_WAIT: begin
                    r_x     <= w_step_x;
                    r_y     <= w_step_y;
                    r_state <= ST_IDLE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cursor_x    = r_x;
    assign cursor_y    = r_y;
    assign selected    = r_sel;
    assign op_valid    = r_op_valid;
    assign op_code     = r_op_code;
    assign match_req   = r_match_req;
    assign fall_req    = r_fall_req;
    assign chain_done  = r_chain_done;
    assign combo       = r_combo;
    assign err_timeout = r_err;
    assign busy        = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_swap_sequencer.sv
module tb_swap_sequencer;
    import game_pkg::*;

    localparam int TO = 1024;
    localparam int B_C = 0, B_U = 1, B_D = 2, B_L = 3, B_R = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_center = 0;
    logic op_moved = 0, match_done = 0, match_found = 0, fall_done = 0;

    logic [3:0] cursor_x, cursor_y, op_code;
    logic selected, op_valid, match_req, fall_req, busy, chain_done, err_timeout;
    logic [3:0] combo;
    logic [2:0] dbg_state;

    // second instance with a 2-bit combo counter, driven by the same inputs
    logic [3:0] x2, y2, op_code2;
    logic sel2, op_valid2, match_req2, fall_req2, busy2, chain_done2, err2;
    logic [1:0] combo2;
    logic [2:0] dbg_state2;

    swap_sequencer #(.BOARD_N(8), .COMBO_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .selected(selected),
        .op_valid(op_valid), .op_code(op_code), .op_moved(op_moved),
        .match_req(match_req), .match_done(match_done), .match_found(match_found),
        .fall_req(fall_req), .fall_done(fall_done), .busy(busy),
        .chain_done(chain_done), .combo(combo), .err_timeout(err_timeout),
        .dbg_state(dbg_state)
    );

    swap_sequencer #(.BOARD_N(8), .COMBO_W(2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_center(btn_center),
        .cursor_x(x2), .cursor_y(y2), .selected(sel2),
        .op_valid(op_valid2), .op_code(op_code2), .op_moved(op_moved),
        .match_req(match_req2), .match_done(match_done), .match_found(match_found),
        .fall_req(fall_req2), .fall_done(fall_done), .busy(busy2),
        .chain_done(chain_done2), .combo(combo2), .err_timeout(err2),
        .dbg_state(dbg_state2)
    );

    int checks = 0;
    int errors = 0;
    int n_op = 0, n_fall = 0, n_chain = 0;

    // strobe counters: sample the previous cycle's registered strobes
    always @(posedge clk) begin
        if (op_valid)   n_op++;
        if (fall_req)   n_fall++;
        if (chain_done) n_chain++;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int b);
        case (b)
            B_C: btn_center = 1'b1;
            B_U: btn_up     = 1'b1;
            B_D: btn_down   = 1'b1;
            B_L: btn_left   = 1'b1;
            default: btn_right = 1'b1;
        endcase
        @(negedge clk);
        btn_center = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
    endtask

    task automatic drive_match(input logic found);
        match_done = 1'b1; match_found = found;
        @(negedge clk);
        match_done = 1'b0; match_found = 1'b0;
    endtask

    task automatic drive_fall();
        fall_done = 1'b1;
        @(negedge clk);
        fall_done = 1'b0;
    endtask

    // select, press direction, operate reports moved -> ends in CHECK
    task automatic start_swap(input int b);
        press(B_C);
        press(b);
        op_moved = 1'b1;
        @(negedge clk);
        op_moved = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        checks++; if (cursor_x !== 4'd0) begin errors++; $display("FAIL rst_x got %0d exp 0", cursor_x); end
        checks++; if (cursor_y !== 4'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", cursor_y); end
        checks++; if ({selected, op_valid, match_req, fall_req, chain_done} !== 5'b0) begin errors++; $display("FAIL rst_strobes got %b exp 00000", {selected, op_valid, match_req, fall_req, chain_done}); end
        checks++; if (combo !== 4'd0) begin errors++; $display("FAIL rst_combo got %0d exp 0", combo); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_clamp();
        press(B_L);
        press(B_U);
        checks++; if ({cursor_x, cursor_y} !== 8'h00) begin errors++; $display("FAIL clamp_origin got %0d,%0d exp 0,0", cursor_x, cursor_y); end
        for (int i = 0; i < 7; i++) press(B_R);
        checks++; if (cursor_x !== 4'd7) begin errors++; $display("FAIL clamp_right7 got %0d exp 7", cursor_x); end
        press(B_R);
        checks++; if (cursor_x !== 4'd7) begin errors++; $display("FAIL clamp_right8 got %0d exp 7", cursor_x); end
        // selected at the right/top edges: edge-ward moves ignored, selection kept
        press(B_C);
        press(B_R);
        press(B_U);
        checks++; if ({selected, busy} !== 2'b10) begin errors++; $display("FAIL edge_ignore sel,busy got %b exp 10", {selected, busy}); end
        checks++; if ({cursor_x, cursor_y} !== 8'h70) begin errors++; $display("FAIL edge_pos got %0d,%0d exp 7,0", cursor_x, cursor_y); end
        press(B_C);
        checks++; if (selected !== 1'b0) begin errors++; $display("FAIL deselect got %b exp 0", selected); end
        // center has priority over a simultaneous direction
        btn_center = 1'b1; btn_left = 1'b1;
        tick(1);
        btn_center = 1'b0; btn_left = 1'b0;
        checks++; if ({selected, cursor_x} !== {1'b1, 4'd7}) begin errors++; $display("FAIL center_prio got sel %b x %0d exp sel 1 x 7", selected, cursor_x); end
        press(B_C);
    endtask

    task automatic test_swap_success();
        int f0;
        int c0;
        for (int i = 0; i < 4; i++) press(B_L);
        for (int i = 0; i < 3; i++) press(B_D);
        checks++; if ({cursor_x, cursor_y} !== 8'h33) begin errors++; $display("FAIL goto33 got %0d,%0d exp 3,3", cursor_x, cursor_y); end
        press(B_C);
        checks++; if (selected !== 1'b1) begin errors++; $display("FAIL select got %b exp 1", selected); end
        f0 = n_fall;
        c0 = n_chain;
        press(B_R);
        checks++; if ({op_valid, op_code} !== {1'b1, OP_RIGHT}) begin errors++; $display("FAIL swap_op got %b/%0d exp 1/%0d", op_valid, op_code, OP_RIGHT); end
        checks++; if ({busy, cursor_x} !== {1'b1, 4'd3}) begin errors++; $display("FAIL swap_origin got busy %b x %0d exp 1,3", busy, cursor_x); end
        op_moved = 1'b1;
        tick(1);
        op_moved = 1'b0;
        checks++; if ({cursor_x, cursor_y} !== 8'h43) begin errors++; $display("FAIL swap_target got %0d,%0d exp 4,3", cursor_x, cursor_y); end
        checks++; if ({selected, match_req, op_valid} !== 3'b010) begin errors++; $display("FAIL swap_mreq sel,mreq,opv got %b exp 010", {selected, match_req, op_valid}); end
        tick(2);
        drive_match(1'b1);
        checks++; if ({fall_req, match_req} !== 2'b10) begin errors++; $display("FAIL fall_req got %b exp 10", {fall_req, match_req}); end
        tick(2);
        drive_fall();
        checks++; if ({fall_req, match_req} !== 2'b01) begin errors++; $display("FAIL rescan got %b exp 01", {fall_req, match_req}); end
        tick(1);
        drive_match(1'b0);
        checks++; if ({chain_done, busy, combo} !== {1'b1, 1'b1, 4'd1}) begin errors++; $display("FAIL chain1 got done %b busy %b combo %0d exp 1 1 1", chain_done, busy, combo); end
        tick(1);
        checks++; if ({chain_done, busy, combo} !== {1'b0, 1'b0, 4'd1}) begin errors++; $display("FAIL after_done got done %b busy %b combo %0d exp 0 0 1", chain_done, busy, combo); end
        tick(1);
        checks++; if (n_fall - f0 !== 1) begin errors++; $display("FAIL fall_count got %0d exp 1", n_fall - f0); end
        checks++; if (n_chain - c0 !== 1) begin errors++; $display("FAIL chain_count got %0d exp 1", n_chain - c0); end
    endtask

    task automatic test_swap_revert();
        int c0;
        press(B_L);
        c0 = n_chain;
        start_swap(B_R);
        tick(1);
        drive_match(1'b0);
        checks++; if ({op_valid, op_code} !== {1'b1, OP_LEFT}) begin errors++; $display("FAIL revert_op got %b/%0d exp 1/%0d", op_valid, op_code, OP_LEFT); end
        checks++; if ({cursor_x, cursor_y} !== 8'h43) begin errors++; $display("FAIL revert_from got %0d,%0d exp 4,3", cursor_x, cursor_y); end
        tick(1);
        checks++; if ({cursor_x, cursor_y} !== 8'h33) begin errors++; $display("FAIL revert_back got %0d,%0d exp 3,3", cursor_x, cursor_y); end
        checks++; if ({busy, selected} !== 2'b00) begin errors++; $display("FAIL revert_idle busy,sel got %b exp 00", {busy, selected}); end
        tick(2);
        checks++; if (n_chain !== c0) begin errors++; $display("FAIL revert_no_chain got %0d exp %0d", n_chain, c0); end
        // operate refuses the swap: back to IDLE, deselected, cursor unmoved
        press(B_C);
        press(B_R);
        tick(1);
        checks++; if ({busy, selected, cursor_x} !== {1'b0, 1'b0, 4'd3}) begin errors++; $display("FAIL not_moved got busy %b sel %b x %0d exp 0 0 3", busy, selected, cursor_x); end
    endtask

    task automatic test_cascade();
        start_swap(B_R);
        for (int i = 0; i < 3; i++) begin
            drive_match(1'b1);
            drive_fall();
        end
        drive_match(1'b0);
        checks++; if ({chain_done, combo} !== {1'b1, 4'd3}) begin errors++; $display("FAIL combo3 got done %b combo %0d exp 1 3", chain_done, combo); end
        checks++; if ({chain_done2, combo2} !== {1'b1, 2'd3}) begin errors++; $display("FAIL combo3_w2 got done %b combo %0d exp 1 3", chain_done2, combo2); end
        tick(1);
        start_swap(B_R);
        checks++; if (combo !== 4'd0) begin errors++; $display("FAIL combo_clear got %0d exp 0", combo); end
        for (int i = 0; i < 5; i++) begin
            drive_match(1'b1);
            drive_fall();
        end
        drive_match(1'b0);
        checks++; if ({chain_done, combo} !== {1'b1, 4'd5}) begin errors++; $display("FAIL combo5 got done %b combo %0d exp 1 5", chain_done, combo); end
        checks++; if ({chain_done2, combo2} !== {1'b1, 2'd3}) begin errors++; $display("FAIL combo_sat got done %b combo %0d exp 1 3", chain_done2, combo2); end
        tick(1);
        checks++; if ({cursor_x, cursor_y} !== 8'h53) begin errors++; $display("FAIL cascade_pos got %0d,%0d exp 5,3", cursor_x, cursor_y); end
    endtask

    task automatic test_timeout();
        int waited;
        int op0;
        start_swap(B_R);
        op0 = n_op;
        waited = 0;
        press(B_C); waited++;
        press(B_L); waited++;
        press(B_U); waited++;
        fall_done = 1'b1; tick(1); fall_done = 1'b0; waited++;
        checks++; if ({busy, fall_req, err_timeout} !== 3'b100) begin errors++; $display("FAIL wait_check busy,freq,err got %b exp 100", {busy, fall_req, err_timeout}); end
        while (!err_timeout && waited < TO + 50) begin
            tick(1);
            waited++;
        end
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got %b exp 1 after %0d cycles", err_timeout, waited); end
        checks++; if (waited !== TO) begin errors++; $display("FAIL timeout_cycles got %0d exp %0d", waited, TO); end
        checks++; if ({busy, selected} !== 2'b00) begin errors++; $display("FAIL timeout_idle busy,sel got %b exp 00", {busy, selected}); end
        checks++; if ({cursor_x, cursor_y} !== 8'h63) begin errors++; $display("FAIL busy_btn_pos got %0d,%0d exp 6,3", cursor_x, cursor_y); end
        checks++; if (n_op !== op0) begin errors++; $display("FAIL busy_btn_op got %0d exp %0d", n_op, op0); end
        drive_match(1'b1);
        checks++; if ({fall_req, busy} !== 2'b00) begin errors++; $display("FAIL late_done got freq,busy %b exp 00", {fall_req, busy}); end
        tick(3);
        press(B_R);
        checks++; if ({err_timeout, cursor_x} !== {1'b1, 4'd7}) begin errors++; $display("FAIL err_sticky got err %b x %0d exp 1 7", err_timeout, cursor_x); end
    endtask

    task automatic test_reset_mid_check();
        start_swap(B_L);
        checks++; if ({busy, match_req, cursor_x} !== {1'b1, 1'b1, 4'd6}) begin errors++; $display("FAIL pre_rst got busy %b mreq %b x %0d exp 1 1 6", busy, match_req, cursor_x); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({cursor_x, cursor_y} !== 8'h00) begin errors++; $display("FAIL async_rst_pos got %0d,%0d exp 0,0", cursor_x, cursor_y); end
        checks++; if ({busy, match_req, err_timeout} !== 3'b000) begin errors++; $display("FAIL async_rst got busy,mreq,err %b exp 000", {busy, match_req, err_timeout}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        checks++; if ({busy, op_valid, match_req, fall_req, chain_done, selected} !== 6'b0) begin errors++; $display("FAIL post_rst got %b exp 000000", {busy, op_valid, match_req, fall_req, chain_done, selected}); end
        checks++; if ({err_timeout, cursor_x, cursor_y} !== 9'b0) begin errors++; $display("FAIL post_rst_state got err %b pos %0d,%0d exp 0 0,0", err_timeout, cursor_x, cursor_y); end
    endtask

    initial begin
        test_reset();
        test_clamp();
        test_swap_success();
        test_swap_revert();
        test_cascade();
        test_timeout();
        test_reset_mid_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
